// File: rtl/demux1to4.sv
// 1-to-4 demultiplexer with a one-entry holding register per output channel.
// Optional per-channel delivery counters are compiled in with DEMUX1TO4_CNT_EN.
module demux1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S0,
  input  logic             S1,
`ifdef DEMUX1TO4_CNT_EN
  output logic [7:0]       A_cnt,
  output logic [7:0]       B_cnt,
  output logic [7:0]       C_cnt,
  output logic [7:0]       D_cnt,
`endif
  output logic [WIDTH-1:0] A_data,
  output logic [WIDTH-1:0] B_data,
  output logic [WIDTH-1:0] C_data,
  output logic [WIDTH-1:0] D_data,
  output logic             A_valid,
  output logic             B_valid,
  output logic             C_valid,
  output logic             D_valid,
  input  logic             A_ready,
  input  logic             B_ready,
  input  logic             C_ready,
  input  logic             D_ready
);

  logic [1:0]       sel;
  logic [3:0]       sel_oh;
  logic [3:0]       ready_vec;
  logic [3:0]       full_q;
  logic [3:0]       load_vec;
  logic [3:0]       deliver_vec;
  logic [WIDTH-1:0] data_q [4];

  // Channel index 0..3 corresponds to A..D throughout.
  assign sel         = {S0, S1};
  assign sel_oh      = 4'b0001 << sel;
  assign ready_vec   = {D_ready, C_ready, B_ready, A_ready};
  assign in_ready    = rst_n & (|(sel_oh & (~full_q | ready_vec)));
  assign load_vec    = sel_oh & {4{in_valid & in_ready}};
  assign deliver_vec = full_q & ready_vec;

  // A load on the same edge as a delivery keeps the flag set, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_vec[i]) begin
          data_q[i] <= in_data;
          full_q[i] <= 1'b1;
        end else if (deliver_vec[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  assign A_data  = data_q[0];
  assign B_data  = data_q[1];
  assign C_data  = data_q[2];
  assign D_data  = data_q[3];
  assign A_valid = full_q[0];
  assign B_valid = full_q[1];
  assign C_valid = full_q[2];
  assign D_valid = full_q[3];

`ifdef DEMUX1TO4_CNT_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (deliver_vec[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign A_cnt = cnt_q[0];
  assign B_cnt = cnt_q[1];
  assign C_cnt = cnt_q[2];
  assign D_cnt = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1to4.sv
// Randomized and directed bench for demux1to4 against a behavioural channel model.
// Counter checks are active when DEMUX1TO4_CNT_EN is defined.
module tb_demux1to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       S0, S1;
  logic [7:0] A_data, B_data, C_data, D_data;
  logic       A_valid, B_valid, C_valid, D_valid;
  logic       A_ready, B_ready, C_ready, D_ready;
`ifdef DEMUX1TO4_CNT_EN
  logic [7:0] A_cnt, B_cnt, C_cnt, D_cnt;
  logic [7:0] got_cnt [4];
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: one slot per channel, counts kept as plain integers mod 256.
  bit         m_full [4];
  logic [7:0] m_data [4];
  int         m_cnt  [4];

  logic [3:0] got_valid;
  logic [7:0] got_data [4];

  always #5 clk = ~clk;

  demux1to4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .S0(S0), .S1(S1),
`ifdef DEMUX1TO4_CNT_EN
    .A_cnt(A_cnt), .B_cnt(B_cnt), .C_cnt(C_cnt), .D_cnt(D_cnt),
`endif
    .A_data(A_data), .B_data(B_data), .C_data(C_data), .D_data(D_data),
    .A_valid(A_valid), .B_valid(B_valid), .C_valid(C_valid), .D_valid(D_valid),
    .A_ready(A_ready), .B_ready(B_ready), .C_ready(C_ready), .D_ready(D_ready)
  );

  assign got_valid   = {D_valid, C_valid, B_valid, A_valid};
  assign got_data[0] = A_data;
  assign got_data[1] = B_data;
  assign got_data[2] = C_data;
  assign got_data[3] = D_data;
`ifdef DEMUX1TO4_CNT_EN
  assign got_cnt[0] = A_cnt;
  assign got_cnt[1] = B_cnt;
  assign got_cnt[2] = C_cnt;
  assign got_cnt[3] = D_cnt;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("valid%0d", c), {31'd0, got_valid[c]}, {31'd0, m_full[c]});
      if (m_full[c]) checkOutput($sformatf("data%0d", c), {24'd0, got_data[c]}, {24'd0, m_data[c]});
`ifdef DEMUX1TO4_CNT_EN
      checkOutput($sformatf("cnt%0d", c), {24'd0, got_cnt[c]}, m_cnt[c]);
`endif
    end
  endtask

  // Drives one cycle of inputs (called just after a rising edge), checks the
  // combinational in_ready, advances the model at the edge, then checks outputs.
  task automatic applyStimulus(input int ch, input logic [7:0] d, input logic v, input logic [3:0] r);
    bit exp_rdy;
    bit deliver;
    S0 = ch[1];
    S1 = ch[0];
    in_data = d;
    in_valid = v;
    {D_ready, C_ready, B_ready, A_ready} = r;
    exp_rdy = !m_full[ch] || r[ch];
    #2;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      deliver = m_full[c] && r[c];
      if (deliver) m_cnt[c] = (m_cnt[c] + 1) % 256;
      if (v && exp_rdy && c == ch) begin
        m_data[c] = d;
        m_full[c] = 1'b1;
      end else if (deliver) begin
        m_full[c] = 1'b0;
      end
    end
    #1;
    checkAll();
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    {D_ready, C_ready, B_ready, A_ready} = 4'b0000;
    rst_n = 1'b0;
    #2;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rst_valid%0d", c), {31'd0, got_valid[c]}, 32'd0);
      checkOutput($sformatf("rst_data%0d", c), {24'd0, got_data[c]}, 32'd0);
`ifdef DEMUX1TO4_CNT_EN
      checkOutput($sformatf("rst_cnt%0d", c), {24'd0, got_cnt[c]}, 32'd0);
`endif
      m_full[c] = 1'b0;
      m_data[c] = 8'd0;
      m_cnt[c]  = 0;
    end
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = 8'd0;
    in_valid = 1'b0;
    S0 = 1'b0;
    S1 = 1'b0;
    {D_ready, C_ready, B_ready, A_ready} = 4'b0000;
    #1;
    doReset();

    // Route to C in the very first cycle out of reset.
    applyStimulus(2, 8'h5A, 1'b1, 4'b0000);
    checkOutput("route_C_valid", {31'd0, C_valid}, 32'd1);
    checkOutput("route_C_data", {24'd0, C_data}, 32'h5A);
    checkOutput("route_others", {29'd0, A_valid, B_valid, D_valid}, 32'd0);
    applyStimulus(2, 8'h00, 1'b0, 4'b0100);

    // Backpressure on B, then release.
    applyStimulus(1, 8'h33, 1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 8'hC0 + 8'(k), 1'b1, 4'b0000);
      checkOutput("bp_B_data", {24'd0, B_data}, 32'h33);
    end
    applyStimulus(1, 8'h44, 1'b1, 4'b0010);
    checkOutput("bp_B_new", {24'd0, B_data}, 32'h44);
    applyStimulus(1, 8'h00, 1'b0, 4'b0010);

    // Back-to-back streaming into D.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(3, 8'(k), 1'b1, 4'b1000);
      checkOutput("stream_D_valid", {31'd0, D_valid}, 32'd1);
      checkOutput("stream_D_data", {24'd0, D_data}, k);
    end
    applyStimulus(3, 8'h00, 1'b0, 4'b1000);

    // Parallel deliveries on A and C with an accept on B.
    applyStimulus(0, 8'h11, 1'b1, 4'b0000);
    applyStimulus(2, 8'h22, 1'b1, 4'b0000);
    applyStimulus(1, 8'h77, 1'b1, 4'b0101);
    checkOutput("par_valid", {28'd0, D_valid, C_valid, B_valid, A_valid}, 32'b0010);
    applyStimulus(1, 8'h00, 1'b0, 4'b0010);

    // Mid-operation reset with A and D full.
    applyStimulus(0, 8'hA1, 1'b1, 4'b0000);
    applyStimulus(3, 8'hD1, 1'b1, 4'b0000);
    doReset();

`ifdef DEMUX1TO4_CNT_EN
    for (int k = 0; k < 257; k++) applyStimulus(0, 8'(k), 1'b1, 4'b0001);
    checkOutput("cnt_A_wrap", {24'd0, A_cnt}, 32'd0);
    checkOutput("cnt_B_zero", {24'd0, B_cnt}, 32'd0);
    applyStimulus(0, 8'h00, 1'b0, 4'b0001);
    checkOutput("cnt_A_one", {24'd0, A_cnt}, 32'd1);
`endif

    for (int i = 0; i < 600; i++) begin
      if (i % 151 == 75) doReset();
      applyStimulus(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1to4.md
DEMUX1TO4 -- requirements
Module: demux1to4

Interface
REQ-001 Parameter WIDTH, default 8, is the data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_data  input  WIDTH  item to route.
REQ-005 in_valid  input  1  in_data is offered this cycle.
REQ-006 in_ready  output  1  the selected channel can accept in_data this cycle.
REQ-007 S0, S1  input  1 each  channel select; S0 is the MSB. Decode: 00 = A, 01 = B, 10 = C, 11 = D.
REQ-008 A_data, B_data, C_data, D_data  output  WIDTH each  per-channel held item.
REQ-009 A_valid, B_valid, C_valid, D_valid  output  1 each  the channel holds an undelivered item.
REQ-010 A_ready, B_ready, C_ready, D_ready  input  1 each  the downstream consumer takes the channel item this cycle.

Function
REQ-011 Each channel has one holding register (data plus a full flag); X_valid equals that channel's full flag.
REQ-012 in_ready is combinational: it equals (selected channel not full) OR (selected channel full AND its X_ready = 1).
REQ-013 Accept occurs when in_valid = 1 and in_ready = 1. On the next edge the selected channel loads in_data and its full flag is set.
REQ-014 Latency is exactly 1 cycle from accept to X_valid = 1.
REQ-015 Deliver occurs when X_valid = 1 and X_ready = 1. On the next edge the full flag clears, unless the same channel accepts in that cycle.
REQ-016 Simultaneous deliver and accept on the same channel: the old item is delivered, the new item loads, and X_valid stays 1 with no bubble.
REQ-017 Simultaneous deliver on one channel and accept on another: both take effect independently on the same edge.
REQ-018 Deliveries on several channels in the same cycle are all honoured.
REQ-019 Selected channel full and its X_ready = 0: in_ready = 0, no state changes for that channel, and in_data is ignored.
REQ-020 S0/S1 matter only in a cycle where accept occurs; changing the select while stalled is legal and re-evaluates in_ready combinationally.
REQ-021 X_data holds its value while X_valid = 1 and X_ready = 0.
REQ-022 X_data after delivery is don't-care; the bench checks X_data only while X_valid = 1.
REQ-023 Unselected channels never load data.
REQ-024 X_ready asserted while X_valid = 0 has no effect.

Reset
REQ-025 While rst_n = 0, all full flags clear immediately (asynchronously): A_valid through D_valid = 0.
REQ-026 While rst_n = 0, A_data through D_data = 0 and in_ready = 0.
REQ-027 Reset mid-operation discards all held items; no delivery is reported for those items.
REQ-028 The first accept is possible in the first cycle with rst_n = 1.
REQ-029 Counters (if compiled in) reset to 0 asynchronously.

Configuration
REQ-030 Macro DEMUX1TO4_CNT_EN, when defined, adds outputs A_cnt, B_cnt, C_cnt, D_cnt (8 bits each).
REQ-031 With DEMUX1TO4_CNT_EN defined, each X_cnt increments by 1 on every delivery on channel X and wraps from 255 to 0.
REQ-032 Without DEMUX1TO4_CNT_EN, those ports and the counter logic are absent, and all other behaviour is identical.

Verification
REQ-033 Route test: after reset, S0S1 = 10, in_data = 8'h5A, in_valid = 1 for 1 cycle -> next cycle C_valid = 1 and C_data = 8'h5A; A_valid, B_valid and D_valid stay 0.
REQ-034 Backpressure test: B full with B_ready = 0 and S0S1 = 01 -> in_ready = 0; B_data is unchanged over 5 cycles. Then assert B_ready = 1 -> in_ready = 1 in the same cycle.
REQ-035 Streaming test: S0S1 = 11, D_ready held at 1, in_data = 1, 2, 3, 4 offered back-to-back -> D_valid = 1 for 4 consecutive cycles with D_data = 1, 2, 3, 4; no stall occurs.
REQ-036 Parallel test: A and C both full; A_ready = 1, C_ready = 1 and an accept to B occur in the same cycle -> next cycle A_valid = 0, C_valid = 0, B_valid = 1.
REQ-037 Reset test: channels A and D full; rst_n is pulled low mid-cycle -> A_valid and D_valid drop to 0 before the next clock edge, all data reads 0, and no delivery is counted.
REQ-038 Counter test (DEMUX1TO4_CNT_EN defined): 256 deliveries on channel A -> A_cnt = 0 and B_cnt = 0; one further delivery -> A_cnt = 1.
